// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx serial word transmitter.
// Parity frames are enabled by defining PISO_TX_PARITY_EN.
package piso_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Even parity over a word zero-extended to 32 bits; the extension leaves the result unchanged.
  function automatic logic even_par(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, LSB-first serial output.
// `define PISO_TX_PARITY_EN appends an even-parity bit to each frame.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             w_last;
  logic             w_accept;

  assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A load on the last-bit cycle restarts the frame with no idle gap.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shreg_nxt = din;
      w_cnt_nxt   = '0;
    end else if (r_state == SHIFT) begin
      w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
      if (w_last) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + 1'b1;
      end
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_par <= 1'b0;
    else if (w_accept) r_par <= even_par(32'(din));
  end

  // Data bits are exhausted once the counter reaches WIDTH; the held parity goes out last.
  assign dout = (r_state == SHIFT) &&
                ((r_cnt == CW'(WIDTH)) ? r_par : r_shreg[0]);
`else
  assign dout = (r_state == SHIFT) && r_shreg[0];
`endif

  assign dout_valid = (r_state == SHIFT);
  assign dout_last  = w_last;
  assign busy       = (r_state == SHIFT);

endmodule
